// File: rtl/sar_search_if.sv
// rtl/sar_search_if.sv - handshake and comparator bundle for the SAR search controller
interface sar_search_if #(
  parameter int N = 4
);
  logic         start;
  logic         abort;
  logic         cmp_hi;
  logic [N-1:0] trial;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  // Requester side: issues start/abort, closes the comparator loop, observes results
  modport master (
    output start,
    output abort,
    output cmp_hi,
    input  trial,
    input  busy,
    input  done,
    input  result
  );

  // Controller side
  modport slave (
    input  start,
    input  abort,
    input  cmp_hi,
    output trial,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search controller, one bit per SETTLE cycles, MSB first
module sar_search #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_search_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(SETTLE - 1);
  localparam logic [N-1:0]  MSB_ONE = N'(1) << (N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_trial;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_result;

  state_t        w_state_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  w_acc_nxt;
  logic [N-1:0]  w_trial_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [N-1:0]  w_result_nxt;

  // Code after committing the current bit; the bit under test is 0 in r_acc, lower bits stay 0
  logic [N-1:0]  w_acc_dec;
  logic [IW-1:0] w_idx_dec;

  // Next-state and next-output logic; abort outranks a decision edge in the same cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_trial_nxt  = r_trial;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;

    w_acc_dec        = r_acc;
    w_acc_dec[r_idx] = ~bus.cmp_hi;
    w_idx_dec        = r_idx - IW'(1);

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_STEP;
          w_idx_nxt   = IDX_TOP;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_trial_nxt = MSB_ONE;
          w_busy_nxt  = 1'b1;
        end else begin
          w_trial_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      S_STEP: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_trial_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt != CNT_TOP) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else if (r_idx != '0) begin
          w_acc_nxt   = w_acc_dec;
          w_idx_nxt   = w_idx_dec;
          w_cnt_nxt   = '0;
          w_trial_nxt = w_acc_dec | (N'(1) << w_idx_dec);
        end else begin
          w_acc_nxt    = w_acc_dec;
          w_result_nxt = w_acc_dec;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
          w_trial_nxt  = '0;
          w_busy_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_trial_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears a search in flight without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= IDX_TOP;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_trial  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_trial  <= w_trial_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.trial  = r_trial;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - self-checking bench for sar_search with SETTLE=1 and SETTLE=3 instances
module tb_sar_search;

  logic clk;
  logic rst_n;

  logic       sel;       // 0: SETTLE=1 instance, 1: SETTLE=3 instance
  logic       r_start;
  logic       r_abort;
  logic       r_noise;
  logic [3:0] r_tgt;

  int n_checks;
  int n_errors;

  sar_search_if #(.N(4)) if1 ();
  sar_search_if #(.N(4)) if3 ();

  sar_search #(.N(4), .SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  sar_search #(.N(4), .SETTLE(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  // Comparator model: trial above target reports high; noise only flips non-decision cycles
  assign if1.start  = r_start & ~sel;
  assign if1.abort  = r_abort & ~sel;
  assign if1.cmp_hi = (r_tgt < if1.trial) ^ (r_noise & ~sel);
  assign if3.start  = r_start & sel;
  assign if3.abort  = r_abort & sel;
  assign if3.cmp_hi = (r_tgt < if3.trial) ^ (r_noise & sel);

  logic [3:0] w_trial;
  logic [3:0] w_result;
  logic       w_busy;
  logic       w_done;

  assign w_trial  = sel ? if3.trial  : if1.trial;
  assign w_result = sel ? if3.result : if1.result;
  assign w_busy   = sel ? if3.busy   : if1.busy;
  assign w_done   = sel ? if3.done   : if1.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Greedy binary search: trial for step k is the best code so far with the next-lower bit tried
  function automatic int model_trial(input int target, input int k);
    int code;
    int b;
    code = 0;
    for (int i = 0; i < k; i++) begin
      b = 1 << (3 - i);
      if ((code + b) <= target) code = code + b;
    end
    return code + (1 << (3 - k));
  endfunction

  // One complete search; entry is away from a rising edge, exit is mid done-cycle
  task automatic run_search(input bit s, input int target, input bit hold,
                            input bit poke, input bit abort_at_start);
    int st;
    st      = s ? 3 : 1;
    sel     = s;
    r_tgt   = 4'(target);
    r_start = 1'b1;
    r_abort = abort_at_start;
    @(posedge clk); #1;
    r_abort = 1'b0;
    r_start = hold;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < st; j++) begin
        r_noise = (j != st - 1) ? 1'($urandom) : 1'b0;
        r_start = hold | (poke & 1'($urandom));
        @(negedge clk);
        check("trial", int'(w_trial), model_trial(target, k));
        check("busy_step", int'(w_busy), 1);
        check("done_step", int'(w_done), 0);
        @(posedge clk); #1;
      end
    end
    r_noise = 1'b0;
    r_start = hold;
    @(negedge clk);
    check("done_pulse", int'(w_done), 1);
    check("busy_done", int'(w_busy), 0);
    check("trial_done", int'(w_trial), 0);
    check("result", int'(w_result), target);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    sel      = 1'b0;
    r_start  = 1'b0;
    r_abort  = 1'b0;
    r_noise  = 1'b0;
    r_tgt    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trial1",  int'(if1.trial),  0);
    check("rst_busy1",   int'(if1.busy),   0);
    check("rst_done1",   int'(if1.done),   0);
    check("rst_result1", int'(if1.result), 0);
    check("rst_trial3",  int'(if3.trial),  0);
    check("rst_result3", int'(if3.result), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed SETTLE=1 cases including both range ends
    run_search(1'b0, 11, 1'b0, 1'b0, 1'b0);
    run_search(1'b0, 0,  1'b0, 1'b0, 1'b0);
    run_search(1'b0, 15, 1'b0, 1'b0, 1'b0);

    // SETTLE=3 with comparator glitches off the decision edges
    run_search(1'b1, 5, 1'b0, 1'b0, 1'b0);

    // start held high: back-to-back searches
    run_search(1'b0, 3, 1'b1, 1'b0, 1'b0);
    run_search(1'b0, 9, 1'b0, 1'b0, 1'b0);

    // Abort at the second decision edge after a completed result of 11
    run_search(1'b0, 11, 1'b0, 1'b0, 1'b0);
    sel     = 1'b0;
    r_tgt   = 4'd6;
    r_start = 1'b1;
    @(posedge clk); #1;
    r_start = 1'b0;
    @(negedge clk);
    check("abort_trial0", int'(w_trial), 8);
    @(posedge clk); #1;
    r_abort = 1'b1;
    @(negedge clk);
    check("abort_trial1", int'(w_trial), 4);
    @(posedge clk); #1;
    r_abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(w_busy), 0);
    check("abort_trial", int'(w_trial), 0);
    check("abort_done", int'(w_done), 0);
    check("abort_result", int'(w_result), 11);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_nodone", int'(w_done), 0);

    // start pulses during busy are ignored; start+abort in idle starts anyway
    run_search(1'b0, 6,  1'b0, 1'b1, 1'b0);
    run_search(1'b0, 10, 1'b0, 1'b0, 1'b1);
    run_search(1'b1, 12, 1'b0, 1'b1, 1'b1);

    // Randomized searches across both instances
    for (int n = 0; n < 24; n++) begin
      run_search(1'($urandom), int'($urandom_range(15)), 1'b0, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-search
    @(posedge clk); #1;
    sel     = 1'b0;
    r_tgt   = 4'd13;
    r_start = 1'b1;
    @(posedge clk); #1;
    r_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_trial",   int'(if1.trial),  0);
    check("mid_rst_busy",    int'(if1.busy),   0);
    check("mid_rst_done",    int'(if1.done),   0);
    check("mid_rst_result",  int'(if1.result), 0);
    check("mid_rst_result3", int'(if3.result), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_done", int'(w_done), 0);
      check("post_rst_busy", int'(w_busy), 0);
    end
    run_search(1'b0, int'($urandom_range(15)), 1'b0, 1'b0, 1'b0);
    run_search(1'b1, int'($urandom_range(15)), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
